// File: rtl/dac_frame_scheduler.sv
// Round-robin scheduler that shares one serial DAC port between NUM_CH sample requesters.
// Each grant sends a 16-bit frame MSB-first, pulses the load strobe, then idles for one gap.
module dac_frame_scheduler #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DAC_W  = 12
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  input  logic                      enable,
  input  logic [7:0]                clk_div,
  input  logic [NUM_CH-1:0]         ch_req,
  input  logic [NUM_CH*DAC_W-1:0]   ch_data,
  output logic [NUM_CH-1:0]         ch_ack,
  output logic                      sclk,
  output logic                      sync_n,
  output logic                      sdin,
  output logic                      ldac_n,
  output logic                      busy,
  output logic [15:0]               frame_cnt
);

  typedef enum logic [1:0] {StIdle, StShift, StLdac, StGap} state_e;

  state_e              state_q;
  logic [1:0]          ptr_q;
  logic [15:0]         frame_q;
  logic [7:0]          h_q;
  logic [7:0]          cnt_q;
  logic [3:0]          bit_q;
  logic [NUM_CH-1:0]   ack_q;
  logic                sclk_q;
  logic                sync_n_q;
  logic                sdin_q;
  logic                ldac_n_q;
  logic                busy_q;
  logic [15:0]         frame_cnt_q;

  logic                found;
  logic [1:0]          gnt_idx;
  logic [1:0]          ptr_nxt;
  logic [DAC_W-1:0]    sel_data;
  logic [15:0]         frame_d;
  logic [NUM_CH-1:0]   grant_oh;
  logic                half_done;
  int unsigned         k;

  // First requester at or after the pointer, wrapping modulo NUM_CH.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    k       = 0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      k = (32'(ptr_q) + i) % NUM_CH;
      if (!found && ch_req[k]) begin
        found   = 1'b1;
        gnt_idx = k[1:0];
      end
    end
  end

  always_comb begin
    sel_data  = ch_data[32'(gnt_idx)*DAC_W +: DAC_W];
    frame_d   = 16'(sel_data) | (16'(gnt_idx) << DAC_W);
    ptr_nxt   = 2'((32'(gnt_idx) + 1) % NUM_CH);
    grant_oh  = NUM_CH'(1) << gnt_idx;
    half_done = (cnt_q == h_q);
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      frame_q     <= '0;
      h_q         <= '0;
      cnt_q       <= '0;
      bit_q       <= '0;
      ack_q       <= '0;
      sclk_q      <= 1'b0;
      sync_n_q    <= 1'b1;
      sdin_q      <= 1'b0;
      ldac_n_q    <= 1'b1;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      ack_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (enable && found) begin
            ack_q    <= grant_oh;
            frame_q  <= frame_d;
            h_q      <= clk_div;
            cnt_q    <= '0;
            bit_q    <= 4'd15;
            // Each bit opens with its high phase; data is set up while sclk was low.
            sclk_q   <= 1'b1;
            sync_n_q <= 1'b0;
            sdin_q   <= frame_d[15];
            busy_q   <= 1'b1;
            ptr_q    <= ptr_nxt;
            state_q  <= StShift;
          end
        end
        StShift: begin
          if (half_done) begin
            cnt_q <= '0;
            if (sclk_q) begin
              sclk_q <= 1'b0;
            end else if (bit_q == 4'd0) begin
              sync_n_q <= 1'b1;
              ldac_n_q <= 1'b0;
              state_q  <= StLdac;
            end else begin
              bit_q  <= bit_q - 4'd1;
              sdin_q <= frame_q[bit_q - 4'd1];
              sclk_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StLdac: begin
          if (half_done) begin
            cnt_q    <= '0;
            ldac_n_q <= 1'b1;
            state_q  <= StGap;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StGap: begin
          if (half_done) begin
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            sdin_q      <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 16'd1;
            state_q     <= StIdle;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ch_ack    = ack_q;
  assign sclk      = sclk_q;
  assign sync_n    = sync_n_q;
  assign sdin      = sdin_q;
  assign ldac_n    = ldac_n_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Directed bench for dac_frame_scheduler: table of single-channel frames plus
// hand-written contention, reset, enable-gating and withdrawal sequences.
module tb_dac_frame_scheduler;
  localparam int NUM_CH = 4;
  localparam int DAC_W  = 12;

  logic                    ACLK = 1'b0;
  logic                    ARESETN = 1'b0;
  logic                    enable = 1'b0;
  logic [7:0]              clk_div = 8'd0;
  logic [NUM_CH-1:0]       ch_req = '0;
  logic [NUM_CH*DAC_W-1:0] ch_data = '0;
  logic [NUM_CH-1:0]       ch_ack;
  logic                    sclk, sync_n, sdin, ldac_n, busy;
  logic [15:0]             frame_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int exp_cnt  = 0;

  dac_frame_scheduler #(.NUM_CH(NUM_CH), .DAC_W(DAC_W)) dut (
    .ACLK      (ACLK),
    .ARESETN   (ARESETN),
    .enable    (enable),
    .clk_div   (clk_div),
    .ch_req    (ch_req),
    .ch_data   (ch_data),
    .ch_ack    (ch_ack),
    .sclk      (sclk),
    .sync_n    (sync_n),
    .sdin      (sdin),
    .ldac_n    (ldac_n),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  initial forever #5 ACLK = ~ACLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [3:0]  req;
    logic [11:0] data;
    logic [7:0]  div;
    int          ev_kind;  // 0 none, 1 drop enable, 2 clk_div->0, 3 one-cycle ch_req[3]
    int          ev_at;
    logic [3:0]  exp_ack;
    logic [15:0] exp_frame;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Waits for an ack, then follows the frame until busy drops, decoding sdin at sclk falls.
  task automatic watch_frame(input int budget, input bit drop, input int ev_kind,
                             input int ev_at, output logic [3:0] ack, output logic [15:0] f,
                             output int busy_c, output int ldac_c, output int falls,
                             output int extra, output int wait_c);
    logic prev;
    int   n;
    ack = '0; f = '0; busy_c = 0; ldac_c = 0; falls = 0; extra = 0;
    for (wait_c = 0; wait_c < budget; wait_c++) begin
      @(negedge ACLK);
      if (ch_ack != '0) break;
    end
    if (ch_ack == '0) return;
    ack = ch_ack;
    if (drop) ch_req = '0;
    prev = sclk;
    n = 0;
    while (busy && n < budget) begin
      busy_c++;
      if (!ldac_n) ldac_c++;
      if (n == ev_at) begin
        case (ev_kind)
          1: enable = 1'b0;
          2: clk_div = 8'd0;
          3: ch_req[3] = 1'b1;
          default: ;
        endcase
      end
      if (ev_kind == 3 && n == ev_at + 1) ch_req[3] = 1'b0;
      @(negedge ACLK);
      n++;
      if (ch_ack != '0) extra++;
      if (prev && !sclk) begin
        f = {f[14:0], sdin};
        falls++;
      end
      prev = sclk;
    end
  endtask

  task automatic set_all_data(input logic [11:0] v);
    for (int c = 0; c < NUM_CH; c++) ch_data[c*DAC_W +: DAC_W] = v;
  endtask

  initial begin
    logic [3:0]  ack;
    logic [15:0] f;
    logic [11:0] slice;
    int busy_c, ldac_c, falls, extra, wait_c, prev_busy, h;
    bit got;

    vecs[0] = '{4'b0100, 12'hABC, 8'd0, 0, -1, 4'b0100, 16'h2ABC};
    vecs[1] = '{4'b0001, 12'h000, 8'd0, 0, -1, 4'b0001, 16'h0000};
    vecs[2] = '{4'b1000, 12'hFFF, 8'd1, 0, -1, 4'b1000, 16'h3FFF};
    vecs[3] = '{4'b0010, 12'h123, 8'd3, 2, 20, 4'b0010, 16'h1123};
    vecs[4] = '{4'b0100, 12'h5A5, 8'd0, 3, 10, 4'b0100, 16'h25A5};
    vecs[5] = '{4'b0001, 12'h801, 8'd2, 0, -1, 4'b0001, 16'h0801};

    // Reset values
    repeat (3) @(negedge ACLK);
    check("rst_ack", 32'(ch_ack), 0);
    check("rst_sclk", 32'(sclk), 0);
    check("rst_sync_n", 32'(sync_n), 1);
    check("rst_sdin", 32'(sdin), 0);
    check("rst_ldac_n", 32'(ldac_n), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);

    // Contention: all channels held high for five frames
    ARESETN = 1'b1;
    enable  = 1'b1;
    clk_div = 8'd0;
    for (int c = 0; c < NUM_CH; c++) ch_data[c*DAC_W +: DAC_W] = 12'(c * 12'h111 + 1);
    ch_req = 4'hF;
    prev_busy = 0;
    for (int i = 0; i < 5; i++) begin
      watch_frame(2000, i == 4, 0, -1, ack, f, busy_c, ldac_c, falls, extra, wait_c);
      slice = 12'((i % 4) * 12'h111 + 1);
      check("rr_ack", 32'(ack), 32'(4'b0001 << (i % 4)));
      check("rr_frame", 32'(f), 32'((16'(i % 4) << 12) | 16'(slice)));
      check("rr_extra_ack", 32'(extra), 0);
      if (i > 0) check("rr_spacing_ge34", 32'(prev_busy + 1 + wait_c >= 34), 1);
      prev_busy = busy_c;
      exp_cnt++;
    end
    check("rr_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

    // Table of single-request frames
    foreach (vecs[v]) begin
      clk_div = vecs[v].div;
      enable  = 1'b1;
      for (int c = 0; c < NUM_CH; c++)
        ch_data[c*DAC_W +: DAC_W] = vecs[v].req[c] ? vecs[v].data : ~vecs[v].data;
      ch_req = vecs[v].req;
      h = int'(vecs[v].div) + 1;
      watch_frame(2000, 1'b1, vecs[v].ev_kind, vecs[v].ev_at, ack, f, busy_c, ldac_c, falls,
                  extra, wait_c);
      exp_cnt++;
      check("vec_ack", 32'(ack), 32'(vecs[v].exp_ack));
      check("vec_frame", 32'(f), 32'(vecs[v].exp_frame));
      check("vec_busy_len", 32'(busy_c), 32'(34 * h));
      check("vec_ldac_len", 32'(ldac_c), 32'(h));
      check("vec_sclk_falls", 32'(falls), 16);
      check("vec_extra_ack", 32'(extra), 0);
      check("vec_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    end
    repeat (40) @(negedge ACLK);
    check("withdraw_no_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    check("withdraw_idle", 32'(busy), 0);

    // Reset during bit 7 of a frame from ch2
    clk_div = 8'd0;
    set_all_data(12'h3C3);
    ch_req = 4'b0100;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge ACLK);
      if (ch_ack != '0) got = 1'b1;
    end
    check("mid_rst_grant", 32'(ch_ack), 32'(4'b0100));
    ch_req = '0;
    repeat (16) @(negedge ACLK);
    check("mid_rst_pre_busy", 32'(busy), 1);
    ARESETN = 1'b0;
    @(negedge ACLK);
    check("mid_rst_sclk", 32'(sclk), 0);
    check("mid_rst_sync_n", 32'(sync_n), 1);
    check("mid_rst_ldac_n", 32'(ldac_n), 1);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_frame_cnt", 32'(frame_cnt), 0);
    exp_cnt = 0;
    ARESETN = 1'b1;
    ch_req  = 4'b1010;
    watch_frame(2000, 1'b1, 0, -1, ack, f, busy_c, ldac_c, falls, extra, wait_c);
    exp_cnt++;
    check("post_rst_ack", 32'(ack), 32'(4'b0010));
    check("post_rst_frame", 32'(f), 32'h13C3);
    check("post_rst_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

    // Enable gating
    enable = 1'b0;
    ch_req = 4'hF;
    watch_frame(100, 1'b0, 0, -1, ack, f, busy_c, ldac_c, falls, extra, wait_c);
    check("gate_no_ack", 32'(ack), 0);
    check("gate_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    enable = 1'b1;
    watch_frame(2000, 1'b1, 1, 30, ack, f, busy_c, ldac_c, falls, extra, wait_c);
    exp_cnt++;
    check("en_drop_ack", 32'(ack), 32'(4'b0100));
    check("en_drop_frame", 32'(f), 32'h23C3);
    check("en_drop_busy_len", 32'(busy_c), 34);
    check("en_drop_ldac_len", 32'(ldac_c), 1);
    check("en_drop_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
    ch_req = 4'hF;
    watch_frame(100, 1'b0, 0, -1, ack, f, busy_c, ldac_c, falls, extra, wait_c);
    check("en_off_no_ack", 32'(ack), 0);
    check("en_off_frame_cnt", 32'(frame_cnt), 32'(exp_cnt));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dac_frame_scheduler.md
Name: dac_frame_scheduler

Overview:
- Shares one serial (SPI-style) DAC interface between NUM_CH sample requesters, such as the DAC_MODULE channel registers written over AXI4-Lite.
- Round-robin arbitration picks one channel at a time. The block builds a 16-bit command frame, shifts it out MSB-first, then pulses LDAC_n to update the DAC output.
- Sits between the AXI register slave and the DAC pins. Runs entirely in the AXI clock domain.

Parameters:
- NUM_CH, 4, number of requesting channels; legal range 1..4.
- DAC_W, 12, sample width per channel.

Ports:
- ACLK  in  1  system clock.
- ARESETN  in  1  synchronous, active-low reset.
- enable  in  1  allows new grants when 1.
- clk_div  in  8  SCLK half-period minus 1, in ACLK cycles.
- ch_req  in  NUM_CH  level request per channel.
- ch_data  in  NUM_CH*DAC_W  samples; channel k occupies [k*DAC_W +: DAC_W].
- ch_ack  out  NUM_CH  one-cycle pulse: sample consumed.
- sclk  out  1  DAC serial clock, idle low.
- sync_n  out  1  frame select, active low.
- sdin  out  1  serial data.
- ldac_n  out  1  DAC load strobe, active low.
- busy  out  1  frame in progress.
- frame_cnt  out  16  completed-frame counter.

Behaviour:
- Clocking and reset: one clock (ACLK); reset is synchronous and active-low (ARESETN). All outputs are registered.
- Reset values (the edge where ARESETN=0 applies them, including mid-frame): ch_ack=0, sclk=0, sync_n=1, sdin=0, ldac_n=1, busy=0, frame_cnt=0, FSM=IDLE, round-robin pointer=0.
- H = clk_div+1. H is latched at grant; changes to clk_div mid-frame are ignored.
- Frame format: {2'b00, ch_index[1:0], sample[11:0]} for DAC_W=12. For general DAC_W: ch_index, then sample zero-extended into the low bits of a 16-bit frame. Transmitted MSB first.
- FSM states: IDLE -> SHIFT -> LDAC -> GAP -> IDLE.
- IDLE: at an edge where enable=1 and (ch_req != 0):
  - Select the first requesting channel at or after the pointer, wrapping modulo NUM_CH.
  - Latch the frame; pulse ch_ack[g]=1 for exactly that one cycle.
  - Drive sync_n=0, busy=1, sdin=frame[15]; set pointer=(g+1) mod NUM_CH; go to SHIFT.
- SHIFT: 16 bits; each bit lasts 2H cycles.
  - sclk=1 for the first H cycles, 0 for the second H cycles.
  - sdin updates only at the start of each bit, while sclk is low. The DAC samples on the sclk falling edge.
  - After bit 0's low phase: sync_n=1, ldac_n=0, go to LDAC.
- LDAC: hold ldac_n=0 for H cycles, then ldac_n=1 and go to GAP.
- GAP: H cycles with sync_n=1, then busy=0 and go to IDLE.
  - frame_cnt increments by 1 on GAP exit and wraps from 0xFFFF to 0.
- Timing: grant edge to IDLE re-entry is 34H cycles. With clk_div=0 the next grant is possible 34 cycles after the previous one.
- Requests are level-sensitive. A requester holding ch_req after its ack issues a new request, which waits for its round-robin turn.
- Simultaneous requests: strict round-robin from the pointer; no channel is granted twice while another is pending.
- enable falling mid-frame: the current frame completes normally; no further grants.
- ch_req dropping before grant: no ack and no frame.
- ch_data is sampled only at the grant edge.

Test Plan:
- Single request, clk_div=0: ch_req=4'b0100, ch2 data=0xABC -> ch_ack=4'b0100 for 1 cycle; sdin carries 0x2ABC MSB-first over 16 sclk periods of 2 cycles each; ldac_n low 1 cycle; busy high 34 cycles; frame_cnt=1.
- Contention, all ch_req held high for 5 frames -> ack order ch0, ch1, ch2, ch3, ch0; frame_cnt=5; no two acks within 34 cycles.
- Divider, clk_div=3 (H=4) -> sclk period 8 cycles, ldac_n low 4 cycles, frame length 136 cycles. clk_div changed to 0 mid-frame -> current frame stays at 136 cycles.
- Reset mid-frame: ARESETN=0 during bit 7 -> next edge sclk=0, sync_n=1, ldac_n=1, busy=0, frame_cnt=0. After release, ch_req=4'b1010 -> ch1 granted first (pointer reset to 0).
- Enable gating: enable=0 with ch_req=4'b1111 -> no ack for 100 cycles. enable dropped during SHIFT -> that frame completes with correct bits and LDAC, then no further ack.
- Request withdrawal: ch_req[3] pulsed for 1 cycle while a frame is busy -> no ack[3], no extra frame, frame_cnt unchanged.
